// File: rtl/fpga_ccff_loader_if.sv
// Bitstream word stream into the configuration-chain loader.
interface fpga_ccff_loader_if #(
  parameter int unsigned NUM_CHAINS = 12
);
  logic [NUM_CHAINS-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fpga_ccff_loader.sv
// Configuration-chain loader: shifts one word per prog_clk pulse into the fabric chains and
// sequences pReset, config_enable and I/O isolation around a complete load.
module fpga_ccff_loader #(
  parameter int unsigned NUM_CHAINS    = 12,
  parameter int unsigned CHAIN_LEN     = 1024,
  parameter int unsigned PRESET_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  fpga_ccff_loader_if.slave     in_if,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  prog_clk,
  output logic                  pReset,
  output logic                  config_enable,
  output logic                  IO_ISOL_N,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned CntW    = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PresetW = $clog2(PRESET_CYCLES + 1);
  localparam logic [CntW-1:0]    ChainLast  = CntW'(CHAIN_LEN - 1);
  localparam logic [CntW-1:0]    ChainFull  = CntW'(CHAIN_LEN);
  localparam logic [PresetW-1:0] PresetLast = PresetW'(PRESET_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPreset,
    StShiftLo,
    StShiftHi,
    StDone
  } state_e;

  state_e                state_q;
  logic [PresetW-1:0]    preset_cnt_q;
  logic [CntW-1:0]       shift_cnt_q;
  logic [NUM_CHAINS-1:0] head_q;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state_q      <= StIdle;
      preset_cnt_q <= '0;
      shift_cnt_q  <= '0;
      head_q       <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q      <= StPreset;
            preset_cnt_q <= '0;
            shift_cnt_q  <= '0;
          end
        end
        StPreset: begin
          if (preset_cnt_q == PresetLast) begin
            state_q <= StShiftLo;
          end else begin
            preset_cnt_q <= preset_cnt_q + 1'b1;
          end
        end
        StShiftLo: begin
          if (in_if.in_valid) begin
            head_q  <= in_if.in_data;
            state_q <= StShiftHi;
          end
        end
        StShiftHi: begin
          if (shift_cnt_q != ChainFull) begin
            shift_cnt_q <= shift_cnt_q + 1'b1;
          end
          // Chain heads return to 0 once the last bit has been clocked in.
          if (shift_cnt_q >= ChainLast) begin
            state_q <= StDone;
            head_q  <= '0;
          end else begin
            state_q <= StShiftLo;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Every output is a decode of registered state, so no input reaches an output combinationally.
  assign in_if.in_ready = (state_q == StShiftLo);
  assign prog_clk       = (state_q == StShiftHi);
  assign pReset         = (state_q == StPreset);
  assign config_enable  = (state_q == StPreset) || (state_q == StShiftLo) ||
                          (state_q == StShiftHi);
  assign busy           = config_enable;
  assign IO_ISOL_N      = (state_q == StDone);
  assign done           = (state_q == StDone);
  assign ccff_head      = head_q;

endmodule

// File: tb/tb_fpga_ccff_loader.sv
// Randomized bench for fpga_ccff_loader: per-load arithmetic latency model plus a per-cycle
// scoreboard of shifted words and output-relationship checks.
module tb_fpga_ccff_loader;
  localparam int unsigned NC = 12;
  localparam int unsigned L  = 4;
  localparam int unsigned P  = 2;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [NC-1:0] ccff_head;
  logic          prog_clk, pReset, config_enable, IO_ISOL_N, busy, done;

  fpga_ccff_loader_if #(.NUM_CHAINS(NC)) s_if ();

  fpga_ccff_loader #(
    .NUM_CHAINS   (NC),
    .CHAIN_LEN    (L),
    .PRESET_CYCLES(P)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .in_if        (s_if),
    .ccff_head    (ccff_head),
    .prog_clk     (prog_clk),
    .pReset       (pReset),
    .config_enable(config_enable),
    .IO_ISOL_N    (IO_ISOL_N),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  int            acc_cnt  = 0;
  logic [NC-1:0] exp_q[$];
  int            pulse_idx, pulse_seen, preset_seen;
  logic [NC-1:0] last_head;
  logic          prev_pclk = 1'b0;
  logic [NC-1:0] w_arr[L];
  int            g_arr[L];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string name);
    chk(name, {ccff_head, prog_clk, pReset, config_enable, IO_ISOL_N, busy, done, s_if.in_ready},
        '0);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && !abort && s_if.in_valid && s_if.in_ready) acc_cnt <= acc_cnt + 1;
  end

  // Per-cycle compare against the word scoreboard and the fixed output relationships.
  always @(negedge clk) begin
    if (!reset) begin
      chk("isol_eq_done", IO_ISOL_N, done);
      chk("busy_eq_cfg", busy, config_enable);
      if (prog_clk) begin
        chk("pclk_width", prev_pclk, 0);
        chk("pclk_during_preset", pReset, 0);
        chk("ready_during_pclk", s_if.in_ready, 0);
        if (pulse_idx < exp_q.size()) begin
          chk("head_at_pulse", ccff_head, exp_q[pulse_idx]);
          last_head = exp_q[pulse_idx];
        end else begin
          chk("pulse_extra", pulse_idx, exp_q.size());
        end
        pulse_idx++;
        pulse_seen++;
      end
      if (s_if.in_ready) begin
        chk("ready_busy", busy, 1);
        chk("ready_preset", pReset, 0);
        chk("head_hold", ccff_head, last_head);
      end
      if (pReset) begin
        preset_seen++;
        chk("preset_cfg", config_enable, 1);
      end
      if (done) chk("done_outputs", {ccff_head, config_enable, busy, prog_clk}, 0);
      prev_pclk = prog_clk;
    end
  end

  task automatic clear_model();
    exp_q.delete();
    pulse_idx   = 0;
    pulse_seen  = 0;
    preset_seen = 0;
    last_head   = '0;
  endtask

  // start_at: word index whose SHIFT_LO cycle also carries a start pulse (-1: none).
  // abort_after: abort in the SHIFT_HI following that many words (0: complete the load).
  task automatic run_load(input int start_at, input int abort_after, input int exp_lat);
    int t0, bound, acc0;
    clear_model();
    acc0 = acc_cnt;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_to_preset", {pReset, IO_ISOL_N, busy}, 3'b101);
    for (int k = 0; k < int'(L); k++) begin
      bound = 0;
      while (!s_if.in_ready && bound < 100) begin
        @(negedge clk);
        bound++;
      end
      if (bound >= 100) begin
        chk("ready_timeout", 0, 1);
        return;
      end
      repeat (g_arr[k]) @(negedge clk);
      if (k == start_at) start = 1'b1;
      s_if.in_data  = w_arr[k];
      s_if.in_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back(w_arr[k]);
      @(negedge clk);
      s_if.in_valid = 1'b0;
      s_if.in_data  = NC'($urandom);
      start = 1'b0;
      if (abort_after == k + 1) begin
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check_idle("abort_mid_shift");
        return;
      end
    end
    bound = 0;
    while (!done && bound < 200) begin
      @(negedge clk);
      bound++;
    end
    chk("latency", cyc - t0, exp_lat);
    chk("pulse_count", pulse_seen, L);
    chk("preset_len", preset_seen, P);
    chk("words_consumed", acc_cnt - acc0, L);
  endtask

  function automatic int model_latency();
    int s = 1 + int'(P) + 2 * int'(L);
    for (int k = 0; k < int'(L); k++) s += g_arr[k];
    return s;
  endfunction

  task automatic set_basic(input int stall_word, input int stall_len);
    for (int k = 0; k < int'(L); k++) begin
      w_arr[k] = NC'(1 << k);
      g_arr[k] = (k == stall_word) ? stall_len : 0;
    end
  endtask

  initial begin
    int n, bound;
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    s_if.in_valid = 1'b0;
    s_if.in_data  = '0;
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_state");

    set_basic(-1, 0);
    run_load(-1, 0, 11);
    set_basic(2, 3);
    run_load(-1, 0, 14);
    set_basic(-1, 0);
    run_load(1, 0, 11);

    run_load(-1, 2, 0);
    run_load(-1, 0, 11);

    // abort and start together in DONE
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle("abort_start_done");

    // abort together with a handshake in SHIFT_LO
    clear_model();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    bound = 0;
    while (!s_if.in_ready && bound < 50) begin
      @(negedge clk);
      bound++;
    end
    chk("ready_reached", s_if.in_ready, 1);
    s_if.in_data  = 12'hABC;
    s_if.in_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_if.in_valid = 1'b0;
    abort = 1'b0;
    repeat (3) begin
      check_idle("abort_handshake");
      @(negedge clk);
    end

    // reset during PRESET
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("in_preset", pReset, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_mid_preset");
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (prog_clk) n++;
    end
    chk("no_pulse_after_reset", n, 0);

    repeat (20) begin
      for (int k = 0; k < int'(L); k++) begin
        w_arr[k] = NC'($urandom);
        g_arr[k] = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      end
      run_load(int'($urandom_range(0, L)) - 1, 0, model_latency());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
